// File: rtl/mem_dados_sub.sv
// Byte/half/word data memory: registered-read RAM, valid/ready requests, 1-cycle response pulse, RMW sub-word stores.
// Optional misalignment trap enabled by defining MEM_DADOS_MISALIGN_TRAP_EN.
module mem_dados_sub #(
  parameter int DEPTH_LOG2 = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [31:0]       dado_escrita,
  input  logic              sinal_escrita,
  input  logic [1:0]        tamanho,
  input  logic              sem_sinal,
  output logic              resp_valid,
  output logic [31:0]       dado_saida,
  output logic              erro
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RMW  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            tam_q, tam_d;
  logic                  sem_q, sem_d;
  logic [15:0]           wlo_q, wlo_d;
  logic                  resp_q, resp_d;
  logic [31:0]           dout_q, dout_d;

  logic [31:0]           ram_q [DEPTH];
  logic [31:0]           rd_data_q;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  accept;
  logic                  misalign;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_wa;
  logic [31:0]           mem_wd;
  logic [4:0]            lane_sh;
  logic [31:0]           shifted;
  logic [31:0]           lane_mask;
  logic [31:0]           load_val;
  logic [31:0]           merge_val;
  logic                  unused_addr;

  // Upper address bits alias onto the same words.
  assign req_idx     = endereco[DEPTH_LOG2+1:2];
  assign unused_addr = ^endereco[ADDR_W-1:DEPTH_LOG2+2];
  assign req_ready   = (state_q == IDLE) && !reset;
  assign accept      = req_valid && req_ready;

`ifdef MEM_DADOS_MISALIGN_TRAP_EN
  logic erro_q, erro_d;

  always_comb begin
    misalign = 1'b0;
    if (tamanho == 2'b01) begin
      misalign = endereco[0];
    end else if (tamanho[1]) begin
      misalign = |endereco[1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= erro_d;
    end
  end

  assign erro = erro_q;
`else
  assign misalign = 1'b0;
  assign erro     = 1'b0;
`endif

  // Lane position inside the word for the captured access size.
  always_comb begin
    lane_sh = 5'd0;
    case (tam_q)
      2'b00:   lane_sh = {off_q, 3'b000};
      2'b01:   lane_sh = {off_q[1], 4'b0000};
      default: lane_sh = 5'd0;
    endcase
  end

  always_comb begin
    shifted   = rd_data_q >> lane_sh;
    lane_mask = (tam_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    load_val  = rd_data_q;
    case (tam_q)
      2'b00:   load_val = sem_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = sem_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = rd_data_q;
    endcase
    merge_val = (rd_data_q & ~(lane_mask << lane_sh)) |
                (({16'b0, wlo_q} & lane_mask) << lane_sh);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    tam_d   = tam_q;
    sem_d   = sem_q;
    wlo_d   = wlo_q;
    resp_d  = 1'b0;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    mem_wa  = idx_q;
    mem_wd  = merge_val;
`ifdef MEM_DADOS_MISALIGN_TRAP_EN
    erro_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d = req_idx;
          off_d = endereco[1:0];
          tam_d = tamanho;
          sem_d = sem_sinal;
          wlo_d = dado_escrita[15:0];
          if (misalign) begin
            resp_d = 1'b1;
`ifdef MEM_DADOS_MISALIGN_TRAP_EN
            erro_d = 1'b1;
`endif
          end else if (sinal_escrita && tamanho[1]) begin
            // Full-word store needs no read, so it completes at the accept edge.
            mem_we = 1'b1;
            mem_wa = req_idx;
            mem_wd = dado_escrita;
            resp_d = 1'b1;
          end else if (sinal_escrita) begin
            state_d = RMW;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        dout_d  = load_val;
        resp_d  = 1'b1;
        state_d = IDLE;
      end
      RMW: begin
        mem_we  = 1'b1;
        resp_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      off_q   <= 2'b00;
      tam_q   <= 2'b00;
      sem_q   <= 1'b0;
      wlo_q   <= 16'h0000;
      resp_q  <= 1'b0;
      dout_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      tam_q   <= tam_d;
      sem_q   <= sem_d;
      wlo_q   <= wlo_d;
      resp_q  <= resp_d;
      dout_q  <= dout_d;
    end
  end

  // RAM contents survive reset; mem_we is already inert while reset holds the FSM in IDLE.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      ram_q[mem_wa] <= mem_wd;
    end
    rd_data_q <= ram_q[req_idx];
  end

  assign resp_valid = resp_q;
  assign dado_saida = dout_q;

endmodule

// File: tb/tb_mem_dados_sub.sv
// Self-checking bench for mem_dados_sub: directed vector table, hand sequences, randomized ops vs byte-level model.
module tb_mem_dados_sub;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] endereco;
  logic [31:0] dado_escrita;
  logic        sinal_escrita;
  logic [1:0]  tamanho;
  logic        sem_sinal;
  logic        resp_valid;
  logic [31:0] dado_saida;
  logic        erro;

  always #5 clock = ~clock;

  mem_dados_sub #(.DEPTH_LOG2(8), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .endereco(endereco), .dado_escrita(dado_escrita), .sinal_escrita(sinal_escrita),
    .tamanho(tamanho), .sem_sinal(sem_sinal), .resp_valid(resp_valid),
    .dado_saida(dado_saida), .erro(erro)
  );

`ifdef MEM_DADOS_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  tam;
    logic        sem;
    int          lat;
    logic [31:0] dout;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  // Byte-addressed reference memory (1 KiB = 256 words).
  logic [7:0]  mb [1024];
  logic [31:0] last_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic we,
                              input logic [1:0] tam, input logic sem, input int lat,
                              input logic [31:0] dout, input logic err);
    vec_t v;
    v.addr = a; v.wdata = d; v.we = we; v.tam = tam; v.sem = sem;
    v.lat = lat; v.dout = dout; v.err = err;
    return v;
  endfunction

  function automatic int size_of(input logic [1:0] tam);
    return (tam == 2'b00) ? 1 : (tam == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int n, input logic sem);
    int base;
    logic [31:0] v;
    base = (int'(a % 1024) / n) * n;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
    if (!sem && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input int n, input logic [31:0] d);
    int base;
    base = (int'(a % 1024) / n) * n;
    for (int i = 0; i < n; i++) mb[base + i] = 8'(d >> (8 * i));
  endtask

  // Starts at a negedge; returns at the negedge where resp_valid is seen (lat = cycles after accept).
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [1:0] tam, input logic sem, output int lat);
    int w;
    w = 0;
    endereco = a; dado_escrita = d; sinal_escrita = we; tamanho = tam; sem_sinal = sem;
    req_valid = 1'b1;
    while (!req_ready && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    endereco = $urandom; dado_escrita = $urandom; sinal_escrita = 1'($urandom);
    tamanho = 2'($urandom); sem_sinal = 1'($urandom);
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] w10;

    reset = 1'b1; req_valid = 1'b0; endereco = 32'h0; dado_escrita = 32'h0;
    sinal_escrita = 1'b0; tamanho = 2'b10; sem_sinal = 1'b0;
    for (int i = 0; i < 1024; i++) mb[i] = 8'h00;
    last_dout = 32'h0;

    repeat (3) @(negedge clock);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_dado_saida", dado_saida, 0);
    chk("rst_erro", erro, 0);
    reset = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 1);
    @(negedge clock);

    tbl.push_back(mk(32'h10,  32'hDEADBEEF, 1, 2'b10, 0, 1, 32'h0000_0000, 0));
    tbl.push_back(mk(32'h10,  32'h0,        0, 2'b10, 0, 2, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(32'h11,  32'h55,       1, 2'b00, 0, 2, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(32'h10,  32'h0,        0, 2'b10, 0, 2, 32'hDEAD_55EF, 0));
    tbl.push_back(mk(32'h13,  32'h0,        0, 2'b00, 0, 2, 32'hFFFF_FFDE, 0));
    tbl.push_back(mk(32'h13,  32'h0,        0, 2'b00, 1, 2, 32'h0000_00DE, 0));
    tbl.push_back(mk(32'h12,  32'h0,        0, 2'b01, 0, 2, 32'hFFFF_DEAD, 0));
    tbl.push_back(mk(32'h400, 32'h12345678, 1, 2'b10, 0, 1, 32'hFFFF_DEAD, 0));
    tbl.push_back(mk(32'h000, 32'h0,        0, 2'b10, 0, 2, 32'h1234_5678, 0));
    tbl.push_back(mk(32'h10,  32'h0,        0, 2'b01, 1, 2, 32'h0000_55EF, 0));
    tbl.push_back(mk(32'h10,  32'hFFFFFF80, 1, 2'b00, 0, 2, 32'h0000_55EF, 0));
    tbl.push_back(mk(32'h10,  32'h0,        0, 2'b00, 0, 2, 32'hFFFF_FF80, 0));
    if (TRAP) tbl.push_back(mk(32'h12, 32'h0, 0, 2'b10, 0, 1, 32'hFFFF_FF80, 1));
    else      tbl.push_back(mk(32'h12, 32'h0, 0, 2'b10, 0, 2, 32'hDEAD_5580, 0));
    tbl.push_back(mk(32'h10,  32'h0,        0, 2'b11, 0, 2, 32'hDEAD_5580, 0));
    tbl.push_back(mk(32'h12,  32'h0000CAFE, 1, 2'b01, 0, 2, 32'hDEAD_5580, 0));
    if (TRAP) tbl.push_back(mk(32'h13, 32'h1234BEEF, 1, 2'b01, 0, 1, 32'hDEAD_5580, 1));
    else      tbl.push_back(mk(32'h13, 32'h1234BEEF, 1, 2'b01, 0, 2, 32'hDEAD_5580, 0));
    if (TRAP) tbl.push_back(mk(32'h10, 32'h0, 0, 2'b10, 0, 2, 32'hCAFE_5580, 0));
    else      tbl.push_back(mk(32'h10, 32'h0, 0, 2'b10, 0, 2, 32'hBEEF_5580, 0));
    if (TRAP) tbl.push_back(mk(32'h11, 32'h0, 0, 2'b01, 0, 1, 32'hCAFE_5580, 1));
    else      tbl.push_back(mk(32'h11, 32'h0, 0, 2'b01, 0, 2, 32'h0000_5580, 0));

    foreach (tbl[i]) begin
      issue(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].tam, tbl[i].sem, lat);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_dado_saida", i), dado_saida, tbl[i].dout);
      chk($sformatf("vec%0d_erro", i), erro, 32'(tbl[i].err));
    end

    // Request held through a load: refused in T+1, accepted in T+2, responses not back-to-back.
    w10 = TRAP ? 32'hCAFE_5580 : 32'hBEEF_5580;
    endereco = 32'h10; tamanho = 2'b10; sinal_escrita = 1'b0; sem_sinal = 1'b0; req_valid = 1'b1;
    chk("held_ready_T", req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    chk("held_ready_T1", req_ready, 0);
    chk("held_resp_T1", resp_valid, 0);
    endereco = 32'h0;
    @(negedge clock);
    chk("held_resp_T2", resp_valid, 1);
    chk("held_dout_T2", dado_saida, w10);
    chk("held_ready_T2", req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("held_resp_T3", resp_valid, 0);
    @(negedge clock);
    chk("held_resp_T4", resp_valid, 1);
    chk("held_dout_T4", dado_saida, 32'h1234_5678);

    // Reset during the RMW cycle must cancel the write and the response.
    issue(32'h20, 32'h11223344, 1, 2'b10, 0, lat);
    chk("rmwrst_seed_lat", lat, 1);
    endereco = 32'h20; dado_escrita = 32'h0000BEEF; sinal_escrita = 1'b1;
    tamanho = 2'b01; sem_sinal = 1'b0; req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rmwrst_resp_T1", resp_valid, 0);
    @(negedge clock);
    chk("rmwrst_resp_T2", resp_valid, 0);
    reset = 1'b0;
    #1;
    chk("rmwrst_dout", dado_saida, 0);
    chk("rmwrst_ready", req_ready, 1);
    @(negedge clock);
    chk("rmwrst_resp_after", resp_valid, 0);
    issue(32'h20, 32'h0, 0, 2'b10, 0, lat);
    chk("rmwrst_load_lat", lat, 2);
    chk("rmwrst_load_val", dado_saida, 32'h1122_3344);
    last_dout = dado_saida;

    // Randomized ops over words 0..15 with random aliasing bits, checked against the byte model.
    for (int k = 0; k < 16; k++) begin
      logic [31:0] d;
      d = $urandom;
      issue(32'(k * 4), d, 1, 2'b10, 0, lat);
      m_store(32'(k * 4), 4, d);
      chk($sformatf("init%0d_lat", k), lat, 1);
    end
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a, d, exp_dout;
      logic        we, sem, mis;
      logic [1:0]  tam;
      int          n, exp_lat;
      a   = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      d   = $urandom;
      we  = 1'($urandom_range(0, 1));
      tam = 2'($urandom_range(0, 3));
      sem = 1'($urandom_range(0, 1));
      n   = size_of(tam);
      mis = TRAP && ((a % n) != 0);
      exp_lat = mis ? 1 : (we && n == 4) ? 1 : 2;
      if (!mis) begin
        if (we) m_store(a, n, d);
        else    last_dout = m_load(a, n, sem);
      end
      exp_dout = last_dout;
      issue(a, d, we, tam, sem, lat);
      chk($sformatf("rnd%0d_lat a=%08h we=%0d tam=%0d", k, a, we, tam), lat, exp_lat);
      chk($sformatf("rnd%0d_dout a=%08h we=%0d tam=%0d sem=%0d", k, a, we, tam, sem), dado_saida, exp_dout);
      chk($sformatf("rnd%0d_erro", k), erro, 32'(mis));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
